// File: rtl/freq_meter_pkg.sv
// Shared definitions for the gate-time frequency meter and its clocking siblings.
// Holds the FSM encoding and the gate-length helpers also used by the clock divider.
package freq_meter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } meter_state_t;

    function automatic int unsigned calc_gate_cycles(
        input int unsigned freq_in,
        input int unsigned gate_freq
    );
        return freq_in / gate_freq;
    endfunction

    // Width of a down-counter that holds values 0 .. cycles-1 (at least one bit).
    function automatic int unsigned calc_cnt_width(input int unsigned cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/freq_meter_signal_synchronizer.sv
// Multi-flop synchroniser for an asynchronous input, followed by a history flop
// that turns the synchronised level into a one-cycle rising-edge pulse.
module signal_synchronizer #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    // History always tracks, so a level that is already high when a window opens is not an edge.
    assign o_sync = r_sync[SYNC_STAGES-1];
    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule

// File: rtl/freq_meter.sv
// Gate-time frequency meter: counts synchronised rising edges of SignalIn over
// back-to-back windows of GATE_CYCLES clocks and publishes each window's count.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned FREQUENCY_IN   = 50_000_000,
    parameter int unsigned GATE_FREQUENCY = 1,
    parameter int unsigned COUNT_WIDTH    = 32,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Enable,
    input  logic                   SignalIn,
    output logic [COUNT_WIDTH-1:0] EdgeCount,
    output logic                   Valid,
    output logic                   Overflow,
    output logic                   Busy
);

    localparam int unsigned GATE_CYCLES = calc_gate_cycles(FREQUENCY_IN, GATE_FREQUENCY);
    localparam int unsigned GATE_WIDTH  = calc_cnt_width(GATE_CYCLES);
    localparam logic [GATE_WIDTH-1:0]  GATE_LOAD = GATE_WIDTH'(GATE_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    meter_state_t           r_state;
    logic [GATE_WIDTH-1:0]  r_gate;
    logic [COUNT_WIDTH-1:0] r_cnt;
    logic                   r_sat;
    logic [COUNT_WIDTH-1:0] r_edge_count;
    logic                   r_overflow;
    logic                   r_valid;

    meter_state_t           w_state_nxt;
    logic [GATE_WIDTH-1:0]  w_gate_nxt;
    logic [COUNT_WIDTH-1:0] w_cnt_nxt;
    logic                   w_sat_nxt;
    logic [COUNT_WIDTH-1:0] w_edge_count_nxt;
    logic                   w_overflow_nxt;
    logic                   w_valid_nxt;

    logic w_sync_level;
    logic w_rise_pulse;
    logic w_edge;
    logic w_at_max;
    logic w_terminal;

    signal_synchronizer #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .Clk     (Clk),
        .Reset   (Reset),
        .i_async (SignalIn),
        .o_sync  (w_sync_level),
        .o_rise  (w_rise_pulse)
    );

    assign w_edge     = w_rise_pulse & w_sync_level;
    assign w_at_max   = (r_cnt == COUNT_MAX);
    assign w_terminal = (r_gate == '0);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state      <= IDLE;
            r_gate       <= '0;
            r_cnt        <= '0;
            r_sat        <= 1'b0;
            r_edge_count <= '0;
            r_overflow   <= 1'b0;
            r_valid      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_gate       <= w_gate_nxt;
            r_cnt        <= w_cnt_nxt;
            r_sat        <= w_sat_nxt;
            r_edge_count <= w_edge_count_nxt;
            r_overflow   <= w_overflow_nxt;
            r_valid      <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_gate_nxt       = r_gate;
        w_cnt_nxt        = r_cnt;
        w_sat_nxt        = r_sat;
        w_edge_count_nxt = r_edge_count;
        w_overflow_nxt   = r_overflow;
        w_valid_nxt      = 1'b0;

        case (r_state)
            IDLE: begin
                w_gate_nxt = '0;
                w_cnt_nxt  = '0;
                w_sat_nxt  = 1'b0;
                if (Enable) begin
                    w_state_nxt = MEASURE;
                    w_gate_nxt  = GATE_LOAD;
                end
            end
            MEASURE: begin
                if (!Enable) begin
                    // Abort wins over a coincident terminal cycle; published result is untouched.
                    w_state_nxt = IDLE;
                    w_gate_nxt  = '0;
                    w_cnt_nxt   = '0;
                    w_sat_nxt   = 1'b0;
                end else if (w_terminal) begin
                    // An edge seen in the terminal cycle closes out with this window.
                    w_edge_count_nxt = (w_edge && !w_at_max) ? r_cnt + 1'b1 : r_cnt;
                    w_overflow_nxt   = r_sat | (w_edge & w_at_max);
                    w_valid_nxt      = 1'b1;
                    w_gate_nxt       = GATE_LOAD;
                    w_cnt_nxt        = '0;
                    w_sat_nxt        = 1'b0;
                end else begin
                    w_gate_nxt = r_gate - 1'b1;
                    if (w_edge) begin
                        if (w_at_max) begin
                            w_sat_nxt = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign EdgeCount = r_edge_count;
    assign Overflow  = r_overflow;
    assign Valid     = r_valid;
    assign Busy      = (r_state == MEASURE);

endmodule
